// File: rtl/cic_decim_mc.sv
// -----------------------------------------------------------------------------
// cic_decim_mc
// Multi-channel CIC decimator. Channels arrive time-multiplexed on one
// Avalon-ST stream. Each channel keeps its own STAGES integrators, comb
// delays (differential delay 1), phase counter and error accumulator. Every
// RATIO-th accepted sample of a channel runs the comb chain in the same cycle
// and loads one result into a single-deep output register.
//
// Optional feature macro: CIC_DECIM_ROUND_EN
//   defined   : round half up before truncation, saturating at +max on overflow
//   undefined : plain truncation of the top OUT_W accumulator bits
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   in_data/in_channel    input sample and its channel index
//   in_error              per-sample error flags, ORed over a decimation window
//   in_startofpacket/in_endofpacket  accepted for bus compatibility, unused
//   in_valid/in_ready     input handshake (in_ready = !out_valid || out_ready)
//   out_data/out_channel  decimated sample and its channel
//   out_error             OR of in_error over the window
//   out_startofpacket     high for channel 0
//   out_endofpacket       high for channel CHANNELS-1
//   out_valid/out_ready   output handshake
// -----------------------------------------------------------------------------
module cic_decim_mc #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int STAGES   = 4,
    parameter int RATIO    = 37,
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic [CH_W-1:0]  in_channel,
    input  logic [1:0]       in_error,
    input  logic             in_startofpacket,
    input  logic             in_endofpacket,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CH_W-1:0]  out_channel,
    output logic [1:0]       out_error,
    output logic             out_startofpacket,
    output logic             out_endofpacket,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int ACC_W = IN_W + STAGES * $clog2(RATIO);
    localparam int PH_W  = $clog2(RATIO);
    localparam int SHIFT = ACC_W - OUT_W;

    // Per-channel state
    logic [ACC_W-1:0] integ_r   [CHANNELS][STAGES];
    logic [ACC_W-1:0] dly_r     [CHANNELS][STAGES];
    logic [PH_W-1:0]  phase_r   [CHANNELS];
    logic [1:0]       err_acc_r [CHANNELS];

    logic             ch_ok_s;
    logic [CH_W-1:0]  ch_idx_s;
    logic             take_s;
    logic             decim_s;
    logic [ACC_W-1:0] x_ext_s;
    logic [ACC_W-1:0] integ_new_s [STAGES];
    logic [ACC_W-1:0] comb_s      [STAGES+1];
    logic [OUT_W-1:0] scaled_s;
    logic [1:0]       err_win_s;
    logic             unused_s;

`ifdef CIC_DECIM_ROUND_EN
    localparam logic [ACC_W-1:0] HALF = (SHIFT > 0) ? (ACC_W'(1) << (SHIFT - 1)) : {ACC_W{1'b0}};
    logic [ACC_W-1:0] rnd_sum_s;
`endif

    // Packet framing inputs carry no meaning for this block.
    assign unused_s = ^{in_startofpacket, in_endofpacket};

    // Single-deep output register: room when empty or being drained.
    assign in_ready = !out_valid || out_ready;

    // Channel qualification, integrator update, comb chain and output scaling.
    always_comb begin
        ch_ok_s  = (int'(in_channel) < CHANNELS);
        // Out-of-range channels index channel 0 but never write it (take_s low).
        ch_idx_s = ch_ok_s ? in_channel : {CH_W{1'b0}};
        take_s   = in_valid && in_ready && ch_ok_s;
        decim_s  = take_s && (phase_r[ch_idx_s] == PH_W'(RATIO - 1));
        x_ext_s  = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

        // Integrator chain includes the current sample.
        integ_new_s[0] = integ_r[ch_idx_s][0] + x_ext_s;
        for (int k = 1; k < STAGES; k++) begin
            integ_new_s[k] = integ_r[ch_idx_s][k] + integ_new_s[k-1];
        end

        // Comb chain evaluated from the freshly updated last integrator.
        comb_s[0] = integ_new_s[STAGES-1];
        for (int k = 0; k < STAGES; k++) begin
            comb_s[k+1] = comb_s[k] - dly_r[ch_idx_s][k];
        end

        err_win_s = err_acc_r[ch_idx_s] | in_error;

`ifdef CIC_DECIM_ROUND_EN
        rnd_sum_s = comb_s[STAGES] + HALF;
        // A non-negative value turning negative means the rounding add overflowed.
        if (!comb_s[STAGES][ACC_W-1] && rnd_sum_s[ACC_W-1]) begin
            scaled_s = {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            scaled_s = rnd_sum_s[ACC_W-1 -: OUT_W];
        end
`else
        scaled_s = comb_s[STAGES][ACC_W-1 -: OUT_W];
`endif
    end

    // Per-channel integrator, comb delay, phase and error window state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                phase_r[c]   <= {PH_W{1'b0}};
                err_acc_r[c] <= 2'b00;
                for (int k = 0; k < STAGES; k++) begin
                    integ_r[c][k] <= {ACC_W{1'b0}};
                    dly_r[c][k]   <= {ACC_W{1'b0}};
                end
            end
        end else if (take_s) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_r[ch_idx_s][k] <= integ_new_s[k];
            end
            if (decim_s) begin
                phase_r[ch_idx_s]   <= {PH_W{1'b0}};
                err_acc_r[ch_idx_s] <= 2'b00;
                for (int k = 0; k < STAGES; k++) begin
                    dly_r[ch_idx_s][k] <= comb_s[k];
                end
            end else begin
                phase_r[ch_idx_s]   <= phase_r[ch_idx_s] + PH_W'(1);
                err_acc_r[ch_idx_s] <= err_win_s;
            end
        end else begin
            phase_r <= phase_r;
        end
    end

    // Output register: load on a decimate, clear valid once drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid         <= 1'b0;
            out_data          <= {OUT_W{1'b0}};
            out_channel       <= {CH_W{1'b0}};
            out_error         <= 2'b00;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
        end else if (decim_s) begin
            out_valid         <= 1'b1;
            out_data          <= scaled_s;
            out_channel       <= ch_idx_s;
            out_error         <= err_win_s;
            out_startofpacket <= (ch_idx_s == {CH_W{1'b0}});
            out_endofpacket   <= (ch_idx_s == CH_W'(CHANNELS - 1));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_cic_decim_mc.sv
// -----------------------------------------------------------------------------
// tb_cic_decim_mc
// Self-checking bench for cic_decim_mc. The reference treats each channel's
// CIC as the equivalent FIR whose taps are STAGES convolved length-RATIO
// boxcars, applied to the channel's accepted-sample history every RATIO-th
// sample, then scaled to OUT_W bits. A single negedge process compares the DUT
// against that model every cycle; directed phases pin the model with
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_cic_decim_mc;

    localparam int IN_W     = 8;
    localparam int OUT_W    = 8;
    localparam int STAGES   = 2;
    localparam int RATIO    = 4;
    localparam int CHANNELS = 3;
    localparam int CH_W     = 2;
    localparam int ACC_W    = IN_W + STAGES * $clog2(RATIO);
    localparam int SHIFT    = ACC_W - OUT_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [IN_W-1:0]  in_data = '0;
    logic [CH_W-1:0]  in_channel = '0;
    logic [1:0]       in_error = 2'b00;
    logic             in_startofpacket = 1'b0;
    logic             in_endofpacket = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic [CH_W-1:0]  out_channel;
    logic [1:0]       out_error;
    logic             out_startofpacket;
    logic             out_endofpacket;
    logic             out_valid;
    logic             out_ready = 1'b1;

    always #5 clk = ~clk;

    cic_decim_mc #(
        .IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .RATIO(RATIO),
        .CHANNELS(CHANNELS), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_channel(in_channel), .in_error(in_error),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_channel(out_channel), .out_error(out_error),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         h[$];
    int         hist[CHANNELS][$];
    int         m_phase[CHANNELS];
    logic [1:0] m_eacc[CHANNELS];
    logic             m_valid = 1'b0;
    logic [OUT_W-1:0] m_data = '0;
    logic [CH_W-1:0]  m_ch = '0;
    logic [1:0]       m_err = 2'b00;
    int   mon_c;
    logic mon_rdy;
    logic mon_dec;

    // Logs of completed output transfers
    int lg_dut[$];
    int lg_mdl[$];
    int lg_ch[$];
    int lg_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string name, input int q[$], input int idx, input int exp);
        if (idx >= q.size()) begin
            chk({name, "_present"}, q.size(), idx + 1);
        end else begin
            chk(name, q[idx], exp);
        end
    endtask

    // FIR taps of the CIC: STAGES-fold convolution of a length-RATIO boxcar.
    task automatic build_h();
        int nh[$];
        int v;
        h.delete();
        h.push_back(1);
        for (int s = 0; s < STAGES; s++) begin
            nh.delete();
            for (int i = 0; i < h.size() + RATIO - 1; i++) begin
                v = 0;
                for (int t = 0; t < RATIO; t++) begin
                    if (i - t >= 0 && i - t < h.size()) v += h[i-t];
                end
                nh.push_back(v);
            end
            h = nh;
        end
    endtask

    function automatic logic [OUT_W-1:0] model_out(input int c);
        longint acc;
        longint m;
        int n;
        acc = 0;
        m = longint'(1) << ACC_W;
        n = hist[c].size();
        for (int j = 0; j < h.size(); j++) begin
            if (n - 1 - j >= 0) acc += longint'(h[j]) * longint'(hist[c][n-1-j]);
        end
        acc = ((acc % m) + m) % m;
        if (acc >= m / 2) acc -= m;
`ifdef CIC_DECIM_ROUND_EN
        acc += longint'(1) << (SHIFT - 1);
        if (acc > m / 2 - 1) return {1'b0, {(OUT_W-1){1'b1}}};
`endif
        acc = acc >>> SHIFT;
        return acc[OUT_W-1:0];
    endfunction

    // Compare DUT to model, then advance the model for the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    hist[c].delete();
                    m_phase[c] = 0;
                    m_eacc[c]  = 2'b00;
                end
                m_valid = 1'b0;
            end else begin
                chk("out_valid", out_valid, m_valid);
                chk("in_ready", in_ready, (!m_valid || out_ready));
                if (m_valid) begin
                    chk("out_data", out_data, m_data);
                    chk("out_channel", out_channel, m_ch);
                    chk("out_error", out_error, m_err);
                    chk("out_sop", out_startofpacket, (m_ch == 0));
                    chk("out_eop", out_endofpacket, (m_ch == CH_W'(CHANNELS - 1)));
                    if (out_ready) begin
                        lg_dut.push_back(int'(out_data));
                        lg_mdl.push_back(int'(m_data));
                        lg_ch.push_back(int'(out_channel));
                        lg_err.push_back(int'(out_error));
                    end
                end
                mon_rdy = !m_valid || out_ready;
                mon_dec = 1'b0;
                mon_c   = int'(in_channel);
                if (in_valid && mon_rdy && mon_c < CHANNELS) begin
                    hist[mon_c].push_back(int'($signed(in_data)));
                    if (hist[mon_c].size() > h.size()) void'(hist[mon_c].pop_front());
                    m_eacc[mon_c] = m_eacc[mon_c] | in_error;
                    if (m_phase[mon_c] == RATIO - 1) begin
                        m_phase[mon_c] = 0;
                        mon_dec = 1'b1;
                        m_data  = model_out(mon_c);
                        m_ch    = CH_W'(mon_c);
                        m_err   = m_eacc[mon_c];
                        m_eacc[mon_c] = 2'b00;
                    end else begin
                        m_phase[mon_c] = m_phase[mon_c] + 1;
                    end
                end
                if (mon_dec) m_valid = 1'b1;
                else if (out_ready) m_valid = 1'b0;
            end
        end
    end

    task automatic drive(input logic v, input int ch, input int d, input logic [1:0] e, input logic r);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_channel = CH_W'(ch);
        in_data    = IN_W'(d);
        in_error   = e;
        out_ready  = r;
    endtask

    task automatic clear_logs();
        lg_dut.delete();
        lg_mdl.delete();
        lg_ch.delete();
        lg_err.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        build_h();

        // Reset held two clocks with in_valid high
        reset = 1'b1; in_valid = 1'b1; in_data = 8'd55; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 8'd0);
        chk("reset_out_error", out_error, 2'b00);
        chk("reset_out_sop", out_startofpacket, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        clear_logs();

        // DC step of 16 on channel 0: 10, 16, 16, 16
        for (int i = 0; i < 16; i++) drive(1'b1, 0, 16, 2'b00, 1'b1);
        repeat (3) drive(1'b0, 0, 0, 2'b00, 1'b1);
        chk_q("dc_dut0", lg_dut, 0, 10);
        chk_q("dc_dut1", lg_dut, 1, 16);
        chk_q("dc_dut3", lg_dut, 3, 16);
        chk_q("dc_mdl0", lg_mdl, 0, 10);
        chk_q("dc_mdl1", lg_mdl, 1, 16);

        // Two-channel interleave +100 / -100
        do_reset();
        for (int i = 0; i < 40; i++) drive(1'b1, i % 2, (i % 2) ? -100 : 100, 2'b00, 1'b1);
        repeat (3) drive(1'b0, 0, 0, 2'b00, 1'b1);
`ifdef CIC_DECIM_ROUND_EN
        chk_q("ilv_first_ch0", lg_mdl, 0, 63);
        chk_q("ilv_first_ch1", lg_mdl, 1, 194);
`else
        chk_q("ilv_first_ch0", lg_mdl, 0, 62);
        chk_q("ilv_first_ch1", lg_mdl, 1, 193);
`endif
        chk_q("ilv_ch_a", lg_ch, 8, 0);
        chk_q("ilv_ch_b", lg_ch, 9, 1);
        chk_q("ilv_pos", lg_dut, 8, 100);
        chk_q("ilv_neg", lg_dut, 9, 156);

        // Backpressure: output stalls, input must be refused, value held
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 0, 16, 2'b00, 1'b0);
        drive(1'b1, 0, 16, 2'b00, 1'b0);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_hold_data", out_data, 8'd10);
        drive(1'b1, 0, 16, 2'b00, 1'b0);
        @(negedge clk);
        chk("bp_hold_data2", out_data, 8'd10);
        for (int i = 0; i < 12; i++) drive(1'b1, 0, 16, 2'b00, 1'b1);
        repeat (3) drive(1'b0, 0, 0, 2'b00, 1'b1);
        chk_q("bp_out0", lg_dut, 0, 10);
        chk_q("bp_out1", lg_dut, 1, 16);
        chk_q("bp_out2", lg_dut, 2, 16);

        // Error on the 3rd sample of the first window only
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 0, 16, (i == 2) ? 2'b01 : 2'b00, 1'b1);
        repeat (3) drive(1'b0, 0, 0, 2'b00, 1'b1);
        chk_q("err_win0", lg_err, 0, 1);
        chk_q("err_win1", lg_err, 1, 0);

        // Full-scale positive DC on channel 2 stays at +max
        do_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 2, 127, 2'b00, 1'b1);
        repeat (3) drive(1'b0, 0, 0, 2'b00, 1'b1);
        chk_q("fs_value", lg_dut, 3, 127);
        chk_q("fs_model", lg_mdl, 3, 127);
        chk_q("fs_channel", lg_ch, 3, 2);

        // Randomised traffic incl. invalid channel, stalls and mid-stream resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            reset      = ($urandom_range(0, 599) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_channel = CH_W'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) in_data = ($urandom_range(0, 1) == 1) ? 8'h7f : 8'h80;
            else in_data = IN_W'($urandom);
            in_error   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            out_ready  = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) drive(1'b0, 0, 0, 2'b00, 1'b1);
        chk("random_outputs_seen", (lg_dut.size() > 100), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
